ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: the address of the first fetch after reset.
REQ-002 clk_i  input  1  the single clock; all state is updated on its rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 redirect_i  input  1  execute stage requests a branch/jump redirect.
REQ-005 redirect_pc_i  input  32  redirect target; bits[1:0] are forced to 0 internally.
REQ-006 imem_req_o  output  1  fetch request to instruction memory.
REQ-007 imem_addr_o  output  32  fetch address; memory samples it only in a cycle where imem_req_o=1 and imem_gnt_i=1.
REQ-008 imem_gnt_i  input  1  memory accepts the current request.
REQ-009 imem_rvalid_i  input  1  returns response data, at least 1 cycle after the grant.
REQ-010 imem_rdata_i  input  32  returned instruction word.
REQ-011 inst_valid_o  output  1  decode-side instruction valid.
REQ-012 inst_o  output  32  instruction to decode and to the immediate extender's din.
REQ-013 inst_pc_o  output  32  PC of inst_o.
REQ-014 inst_ready_i  input  1  decode accepts inst_o.

Function
REQ-015 FSM states: IDLE, REQ, WAIT; at most one memory request is outstanding.
REQ-016 IDLE transition: go to REQ on the first clock edge after reset deasserts, regardless of other inputs.
REQ-017 Request condition: imem_req_o=1 only when state=REQ and FIFO count<2.
REQ-018 Request address: imem_addr_o=fetch_pc whenever imem_req_o=1, and 0 otherwise.
REQ-019 Grant: on a REQ cycle with imem_req_o=1 and imem_gnt_i=1, latch pend_pc=fetch_pc, set fetch_pc to fetch_pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0), and go to WAIT.
REQ-020 Response: in WAIT, when imem_rvalid_i=1, go to REQ; if discard=0 and redirect_i=0, push {pend_pc, imem_rdata_i} into the 2-entry output FIFO.
REQ-021 imem_rvalid_i outside WAIT is ignored.
REQ-022 Output FIFO: 2-entry, in-order, registered; inst_valid_o=(count!=0); inst_o/inst_pc_o show the head entry and are 0 when count=0.
REQ-023 Pop: when inst_valid_o=1, inst_ready_i=1 and redirect_i=0, remove the head entry.
REQ-024 Simultaneous push and pop leaves count unchanged; count never exceeds 2 and never underflows.
REQ-025 Latency: grant at cycle N allows rvalid at N+1 or later; rvalid at cycle M gives inst_valid_o=1 at M+1.
REQ-026 Throughput: peak throughput is 1 instruction per 2 cycles.
REQ-027 Redirect action: when redirect_i=1 in any state, set fetch_pc={redirect_pc_i[31:2],2'b00} and set FIFO count to 0 at the next edge; flush takes priority over pop and push in the same cycle.
REQ-028 Redirect in REQ: with no grant, the request stays asserted and the new address appears next cycle; with a grant in the same cycle, go to WAIT with discard=1 and leave fetch_pc at the redirect target (no +4).
REQ-029 Redirect in WAIT: with no rvalid, set discard=1; with rvalid in the same cycle, drop the data, keep discard=0, and go to REQ.
REQ-030 Redirect in IDLE: load fetch_pc with the target and go to REQ.
REQ-031 Discard: a response arriving with discard=1 is dropped and discard is cleared; a further redirect while discard=1 only updates fetch_pc.
REQ-032 Decode-side stability: inst_o/inst_pc_o do not change while inst_valid_o=1 and inst_ready_i=0, except on a redirect.

Reset
REQ-033 Asynchronous assertion: while rst_n_i=0, state=IDLE, fetch_pc=RESET_PC, pend_pc=0, count=0 and discard=0, independent of clk_i.
REQ-034 Outputs in reset: imem_req_o=0, imem_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0.
REQ-035 Reset mid-operation: reset during WAIT abandons the outstanding request; a late imem_rvalid_i after release is ignored because the state is not WAIT.

Verification
REQ-036 Reset release, then a grant every REQ cycle, rvalid 1 cycle after grant, inst_ready_i=1 -> imem_req_o rises 1 cycle after release at addr 0x0; inst_pc_o sequence 0x0, 0x4, 0x8, one instruction every 2 cycles.
REQ-037 inst_ready_i=0 for 10 cycles -> exactly 2 entries are buffered, imem_req_o=0 afterwards, and the head is held stable; raising ready drains both in order and fetching resumes.
REQ-038 redirect_i=1 with redirect_pc_i=0x0000_0102 while in WAIT -> the pending response is dropped, the next request goes to address 0x100, and the first instruction delivered has inst_pc_o=0x100.
REQ-039 redirect_i coincident with a grant of address 0x20 and with a pop -> the FIFO is empty next cycle, the 0x20 response is dropped, and the next fetch goes to the target.
REQ-040 RESET_PC=0xFFFF_FFFC -> fetch addresses are 0xFFFF_FFFC then 0x0000_0000.
REQ-041 rst_n_i pulsed low during WAIT, then rvalid asserted after release -> no FIFO push, and the refetch starts at RESET_PC.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: single-outstanding memory request FSM feeding a 2-entry
// registered instruction FIFO, with branch redirect and stale-response discard.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       pend_pc_q, pend_pc_d;
    logic              discard_q, discard_d;
    logic [1:0]        count_q, count_d;
    logic [1:0][31:0]  fifo_pc_q, fifo_pc_d;
    logic [1:0][31:0]  fifo_inst_q, fifo_inst_d;

    logic [31:0] redirect_tgt;
    logic        grant, resp, push, pop, wr_idx;

    assign redirect_tgt = redirect_pc_i & 32'hFFFF_FFFC;
    assign grant        = imem_req_o & imem_gnt_i;
    assign resp         = (state_q == StWait) & imem_rvalid_i;
    assign pop          = inst_valid_o & inst_ready_i & ~redirect_i;
    assign push         = resp & ~discard_q & ~redirect_i & ((count_q != 2'd2) | pop);
    // Slot for the incoming entry after an optional same-cycle shift of the head.
    assign wr_idx       = pop ? count_q[1] : count_q[0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StReq;
            StReq:   if (grant) state_d = StWait;
            StWait:  if (imem_rvalid_i) state_d = StReq;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        imem_req_o   = (state_q == StReq) && (count_q < 2'd2);
        imem_addr_o  = imem_req_o ? fetch_pc_q : 32'h0;
        inst_valid_o = (count_q != 2'd0);
        inst_o       = inst_valid_o ? fifo_inst_q[0] : 32'h0;
        inst_pc_o    = inst_valid_o ? fifo_pc_q[0] : 32'h0;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        discard_d  = discard_q;
        if (grant) begin
            pend_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            discard_d  = redirect_i;
        end
        if (resp) begin
            discard_d = 1'b0;
        end else if ((state_q == StWait) && redirect_i) begin
            discard_d = 1'b1;
        end
        if (redirect_i) begin
            fetch_pc_d = redirect_tgt;
        end
    end

    always_comb begin
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
        count_d     = count_q;
        if (redirect_i) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                fifo_pc_d[0]   = fifo_pc_q[1];
                fifo_inst_d[0] = fifo_inst_q[1];
            end
            if (push) begin
                fifo_pc_d[wr_idx]   = pend_pc_q;
                fifo_inst_d[wr_idx] = imem_rdata_i;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc_q  <= RESET_PC;
            pend_pc_q   <= 32'h0;
            discard_q   <= 1'b0;
            count_q     <= 2'd0;
            fifo_pc_q   <= '0;
            fifo_inst_q <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            pend_pc_q   <= pend_pc_d;
            discard_q   <= discard_d;
            count_q     <= count_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_inst_q <= fifo_inst_d;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized traffic
// compared each cycle against a queue-based behavioural model.
module tb_ifetch_unit;

    logic        clk, rst_n;
    logic        redirect, gnt, rvalid, ready;
    logic [31:0] redirect_pc, rdata;
    logic        req, valid;
    logic [31:0] addr, inst, ipc;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_inst, w_ipc;

    int checks, errors;

    ifetch_unit dut (
        .clk_i(clk), .rst_n_i(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt), .imem_rvalid_i(rvalid),
        .imem_rdata_i(rdata), .inst_valid_o(valid), .inst_o(inst), .inst_pc_o(ipc),
        .inst_ready_i(ready)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_n_i(rst_n), .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(1'b1), .imem_rvalid_i(1'b1),
        .imem_rdata_i(32'h0BAD_F00D), .inst_valid_o(w_valid), .inst_o(w_inst),
        .inst_pc_o(w_ipc), .inst_ready_i(1'b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a fetch pointer, one in-flight request (possibly stale), a queue.
    bit          m_started, m_out, m_stale;
    logic [31:0] m_pc, m_opc;
    logic [63:0] m_q[$];

    // Memory responder state.
    bit          mem_busy, spur_en;
    int          mem_cnt, mem_lat;
    logic [31:0] mem_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [97:0] exp_vec();
        logic [63:0] h;
        logic        r;
        h = (m_q.size() != 0) ? m_q[0] : 64'h0;
        r = m_started && !m_out && (m_q.size() < 2);
        return {r, (r ? m_pc : 32'h0), (m_q.size() != 0), h[63:32], h[31:0]};
    endfunction

    function automatic logic [97:0] dut_vec();
        return {req, addr, valid, ipc, inst};
    endfunction

    task automatic model_reset();
        m_started = 0; m_out = 0; m_stale = 0;
        m_pc = 32'h0; m_opc = 32'h0;
        m_q.delete();
    endtask

    task automatic model_step();
        logic        req_now, pop_now;
        logic [31:0] tgt;
        req_now = m_started && !m_out && (m_q.size() < 2);
        pop_now = !redirect && (m_q.size() != 0) && ready;
        tgt     = {redirect_pc[31:2], 2'b00};
        if (pop_now) void'(m_q.pop_front());
        if (redirect) m_q.delete();
        if (!m_started) begin
            m_started = 1;
            if (redirect) m_pc = tgt;
        end else if (req_now && gnt) begin
            m_out = 1; m_opc = m_pc; m_stale = redirect;
            m_pc = redirect ? tgt : m_pc + 32'd4;
        end else if (m_out) begin
            if (rvalid) begin
                if (!m_stale && !redirect) m_q.push_back({m_opc, rdata});
                m_out = 0; m_stale = 0;
            end else if (redirect) begin
                m_stale = 1;
            end
            if (redirect) m_pc = tgt;
        end else if (redirect) begin
            m_pc = tgt;
        end
    endtask

    task automatic set_mem();
        if (mem_busy && mem_cnt == 0) begin
            rvalid = 1'b1; rdata = mem_word(mem_addr);
        end else begin
            rvalid = spur_en && !mem_busy && ($urandom_range(0, 3) == 0);
            rdata  = $urandom;
        end
    endtask

    task automatic tick();
        logic        granted;
        logic [31:0] a;
        granted = (req === 1'b1) && (gnt === 1'b1);
        a = addr;
        model_step();
        if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 0;
            else mem_cnt--;
        end
        if (granted) begin
            mem_busy = 1; mem_cnt = mem_lat - 1; mem_addr = a;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        redirect = 0; redirect_pc = 32'h0; gnt = 0; ready = 0; rvalid = 0; rdata = 32'h0;
        mem_busy = 0; mem_cnt = 0; mem_lat = 1; spur_en = 0;
    endtask

    // Leaves the bench at posedge+1 with reset released and the DUT in its idle cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        gnt = 1; mem_lat = 1;
        for (int c = 0; c < 8; c++) begin
            set_mem();
            tick();
        end
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #2;
        checks++;
        if (dut_vec() !== 98'h0) begin
            errors++;
            $display("FAIL reset_async_outputs got %h exp 0", dut_vec());
        end
        checks++;
        if ({w_req, w_addr, w_valid, w_ipc, w_inst} !== 98'h0) begin
            errors++;
            $display("FAIL reset_async_wrap got %b/%h exp 0", w_req, w_addr);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle_cycle got %h exp %h", dut_vec(), exp_vec());
        end
        gnt = 1;
        set_mem();
        tick();
        checks++;
        if (req !== 1'b1 || addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req got req=%b addr=%h exp req=1 addr=00000000", req, addr);
        end
    endtask

    task automatic test_sequential();
        int          del_cyc[$];
        logic [31:0] del_pc[$];
        do_reset();
        gnt = 1; ready = 1; mem_lat = 1;
        for (int c = 0; c < 14; c++) begin
            set_mem();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL seq_cycle%0d got %h exp %h", c, dut_vec(), exp_vec());
            end
            if (valid === 1'b1) begin
                del_cyc.push_back(c);
                del_pc.push_back(ipc);
            end
            tick();
        end
        checks++;
        if (del_pc.size() < 3) begin
            errors++;
            $display("FAIL seq_count got %0d exp >=3", del_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (del_pc[i] !== 32'(i * 4)) begin
                    errors++;
                    $display("FAIL seq_pc%0d got %h exp %h", i, del_pc[i], 32'(i * 4));
                end
                if (i > 0) begin
                    checks++;
                    if (del_cyc[i] - del_cyc[i-1] != 2) begin
                        errors++;
                        $display("FAIL seq_gap%0d got %0d exp 2", i, del_cyc[i] - del_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        bit          have;
        do_reset();
        gnt = 1; ready = 1; mem_lat = 1; have = 0; held = 32'h0;
        for (int c = 0; c < 4; c++) begin
            set_mem();
            tick();
        end
        ready = 0;
        for (int c = 0; c < 10; c++) begin
            set_mem();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bp_cycle%0d got %h exp %h", c, dut_vec(), exp_vec());
            end
            if (m_q.size() != 0) begin
                if (!have) begin
                    held = m_q[0][63:32];
                    have = 1;
                end
                checks++;
                if (ipc !== held) begin
                    errors++;
                    $display("FAIL bp_head_stable got %h exp %h", ipc, held);
                end
            end
            tick();
        end
        checks++;
        if (req !== 1'b0 || valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full got req=%b valid=%b exp req=0 valid=1", req, valid);
        end
        ready = 1;
        set_mem();
        checks++;
        if (valid !== 1'b1 || ipc !== held) begin
            errors++;
            $display("FAIL bp_drain0 got %b/%h exp 1/%h", valid, ipc, held);
        end
        tick();
        set_mem();
        checks++;
        if (valid !== 1'b1 || ipc !== held + 32'd4 || req !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain1 got v=%b pc=%h req=%b exp v=1 pc=%h req=1",
                     valid, ipc, req, held + 32'd4);
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained got valid=%b exp 0", valid);
        end
    endtask

    task automatic test_redirect_idle();
        do_reset();
        redirect = 1; redirect_pc = 32'h0000_0043;
        tick();
        redirect = 0;
        checks++;
        if (req !== 1'b1 || addr !== 32'h40) begin
            errors++;
            $display("FAIL redir_idle got req=%b addr=%h exp req=1 addr=00000040", req, addr);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL redir_idle_vec got %h exp %h", dut_vec(), exp_vec());
        end
    endtask

    // Shared tail: after a redirect to tgt, the first request and first delivery use tgt.
    task automatic follow_target(input string name, input logic [31:0] tgt);
        bit seen_req, got;
        seen_req = 0; got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            set_mem();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL %s_cycle%0d got %h exp %h", name, c, dut_vec(), exp_vec());
            end
            if (req === 1'b1 && !seen_req) begin
                seen_req = 1;
                checks++;
                if (addr !== tgt) begin
                    errors++;
                    $display("FAIL %s_req_addr got %h exp %h", name, addr, tgt);
                end
            end
            if (valid === 1'b1) begin
                got = 1;
                checks++;
                if (ipc !== tgt || inst !== mem_word(tgt)) begin
                    errors++;
                    $display("FAIL %s_first_inst got %h/%h exp %h/%h",
                             name, ipc, inst, tgt, mem_word(tgt));
                end
            end
            tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout got no delivery exp pc %h", name, tgt);
        end
    endtask

    task automatic test_redirect_wait();
        bit hit;
        do_reset();
        gnt = 1; ready = 1; mem_lat = 3; hit = 0;
        for (int c = 0; c < 10 && !hit; c++) begin
            set_mem();
            hit = (req === 1'b1);
            tick();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rw_grant got none exp grant");
        end
        set_mem();
        redirect = 1; redirect_pc = 32'h0000_0102;
        tick();
        redirect = 0;
        follow_target("rw", 32'h100);
    endtask

    task automatic test_redirect_grant();
        bit hit;
        do_reset();
        gnt = 1; ready = 1; mem_lat = 1; hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            set_mem();
            if (req === 1'b1 && addr === 32'h20) hit = 1;
            else tick();
        end
        checks++;
        if (!hit || valid !== 1'b1) begin
            errors++;
            $display("FAIL rg_setup got hit=%b valid=%b exp 1/1", hit, valid);
        end
        redirect = 1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 0;
        checks++;
        if (valid !== 1'b0 || req !== 1'b0) begin
            errors++;
            $display("FAIL rg_flush got valid=%b req=%b exp 0/0", valid, req);
        end
        follow_target("rg", 32'h200);
    endtask

    task automatic test_wrap();
        logic [31:0] seen[$];
        logic [31:0] first_pc;
        bit          got;
        do_reset();
        got = 0; first_pc = 32'h0;
        for (int c = 0; c < 10; c++) begin
            if (w_req === 1'b1) seen.push_back(w_addr);
            if (w_valid === 1'b1 && !got) begin
                got = 1;
                first_pc = w_ipc;
            end
            tick();
        end
        checks++;
        if (seen.size() < 2 || seen[0] !== 32'hFFFF_FFFC || seen[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addrs got n=%0d first=%h exp FFFFFFFC then 00000000",
                     seen.size(), (seen.size() != 0) ? seen[0] : 32'h0);
        end
        checks++;
        if (!got || first_pc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first_pc got %h exp FFFFFFFC", first_pc);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        do_reset();
        gnt = 1; ready = 1; mem_lat = 3; hit = 0;
        for (int c = 0; c < 10 && !hit; c++) begin
            set_mem();
            hit = (req === 1'b1);
            tick();
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (req !== 1'b0 || valid !== 1'b0 || addr !== 32'h0) begin
            errors++;
            $display("FAIL rm_async got req=%b valid=%b addr=%h exp 0", req, valid, addr);
        end
        model_reset();
        mem_busy = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        gnt = 0; rvalid = 1; rdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (dut_vec() !== exp_vec() || valid !== 1'b0) begin
                errors++;
                $display("FAIL rm_late_rvalid%0d got %h exp %h", c, dut_vec(), exp_vec());
            end
            tick();
        end
        rvalid = 0; gnt = 1; mem_lat = 1;
        follow_target("rm", 32'h0);
    endtask

    task automatic test_random();
        do_reset();
        spur_en = 1;
        for (int c = 0; c < 2000; c++) begin
            mem_lat     = $urandom_range(1, 3);
            gnt         = $urandom_range(0, 1);
            ready       = ($urandom_range(0, 9) < 6);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            set_mem();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rand_cycle%0d got %h exp %h", c, dut_vec(), exp_vec());
            end
            tick();
        end
        redirect = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_idle();
        test_redirect_wait();
        test_redirect_grant();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
